gpio_port: RTL and testbench

Parametrised memory-mapped GPIO peripheral for the PIC subsystem. It replaces the fixed 16-bit `gpio_in`/`gpio_out` pair on the PIC wrapper with a configurable-width port that has:
- per-pin direction control;
- atomic set/clear writes;
- a two-flop input synchronizer;
- masked edge-detect interrupts.

It attaches to the same single-master `address`/`data_in`/`wen`/`ren`/`data_out`/`ready` bus that the PIC wrapper exposes.

---
 rtl/gpio_pkg.sv | 43 ++++
 rtl/gpio_sync_edge.sv | 71 +++++++
 rtl/gpio_port.sv | 203 ++++++++++++++++++++
 tb/tb_gpio_port.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pkg
// Description : Shared constants and types for the gpio_port peripheral:
//               register word offsets (address[4:2]), the bus FSM state
//               type and the write mask for the EDGE register.
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_pkg;

    localparam int GPIO_MAX_WIDTH = 32;

    // Register selectors as seen on address[4:2] (byte offset / 4).
    localparam logic [2:0] GPIO_OUT    = 3'd0;
    localparam logic [2:0] GPIO_DIR    = 3'd1;
    localparam logic [2:0] GPIO_IN     = 3'd2;
    localparam logic [2:0] GPIO_SET    = 3'd3;
    localparam logic [2:0] GPIO_CLR    = 3'd4;
    localparam logic [2:0] GPIO_MASK   = 3'd5;
    localparam logic [2:0] GPIO_STATUS = 3'd6;
    localparam logic [2:0] GPIO_EDGE   = 3'd7;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } gpio_bus_state_t;

    // Writable bits of EDGE: rising enables in [15:0], falling enables in
    // [31:16]; only pins 0..min(width,16)-1 have detectors.
    function automatic logic [31:0] gpio_edge_wmask(input int width);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < width) begin
                m[i]      = 1'b1;
                m[i + 16] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : gpio_sync_edge
// Description : Two-flop synchronizer for the asynchronous pin inputs plus a
//               one-cycle history register used to detect edges.
//               Optional macro: GPIO_IRQ_EN - when undefined the history
//               register and the rise/fall outputs are removed.
// Ports       : clk, reset (async, active high)
//               pin_in [WIDTH] - raw asynchronous pins
//               sync   [WIDTH] - synchronized pin value
//               rise   [WIDTH] - sync & ~prev  (GPIO_IRQ_EN only)
//               fall   [WIDTH] - ~sync & prev  (GPIO_IRQ_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_sync_edge
    import gpio_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] sync
`ifdef GPIO_IRQ_EN
    ,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
`endif
);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = pin_in;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign sync = sync2_q;

`ifdef GPIO_IRQ_EN
    logic [WIDTH-1:0] prev_q, prev_d;

    always_comb begin
        prev_d = sync2_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = sync2_q & ~prev_q;
    assign fall = ~sync2_q & prev_q;
`endif

endmodule
`default_nettype wire

// File: rtl/gpio_port.sv
`default_nettype none
// ============================================================================
// Module      : gpio_port
// Description : Memory-mapped GPIO port: OUT/DIR registers with atomic
//               SET/CLR, synchronized IN, and masked edge interrupts.
//               Optional macro: GPIO_IRQ_EN - enables MASK, STATUS, EDGE,
//               the edge detector and the arm counter; otherwise irq = 0
//               and those registers read 0.
// Ports       : clk, reset (async, active high)
//               address/data_in/wen/ren  - bus request (address[4:2] decoded)
//               data_out/ready           - one-cycle completion strobe + data
//               gpio_in  [WIDTH]         - asynchronous pins
//               gpio_out [WIDTH]         - OUT register
//               gpio_oe  [WIDTH]         - DIR register (1 = drive)
//               irq                      - |(STATUS & MASK)
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_port
    import gpio_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       data_in,
    input  logic              wen,
    input  logic              ren,
    output logic [31:0]       data_out,
    output logic              ready,
    input  logic [WIDTH-1:0]  gpio_in,
    output logic [WIDTH-1:0]  gpio_out,
    output logic [WIDTH-1:0]  gpio_oe,
    output logic              irq
);

    gpio_bus_state_t  state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [31:0]      data_out_q, data_out_d;

    logic [2:0]       w_reg_sel;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_sync;
    logic [31:0]      w_rdata;

    assign w_reg_sel = address[4:2];
    assign w_wdata   = data_in[WIDTH-1:0];

    // Upper address bits are decoded outside; data bits above WIDTH are dropped.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{address, data_in};

`ifdef GPIO_IRQ_EN
    localparam logic [31:0] C_EDGE_WMASK = gpio_edge_wmask(WIDTH);

    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic [31:0]      edge_q, edge_d;
    logic [1:0]       arm_q, arm_d;
    logic [WIDTH-1:0] w_rise, w_fall, w_rise_en, w_fall_en, w_edge_hit;

    gpio_sync_edge #(.WIDTH(WIDTH)) u_sync (
        .clk    (clk),
        .reset  (reset),
        .pin_in (gpio_in),
        .sync   (w_sync),
        .rise   (w_rise),
        .fall   (w_fall)
    );

    // Pins 16 and above have no detector.
    for (genvar i = 0; i < WIDTH; i++) begin : g_edge_en
        if (i < 16) begin : g_det
            assign w_rise_en[i] = edge_q[i];
            assign w_fall_en[i] = edge_q[i + 16];
        end else begin : g_nodet
            assign w_rise_en[i] = 1'b0;
            assign w_fall_en[i] = 1'b0;
        end
    end

    // The sync/prev pipeline fills with the reset-time pin level during the
    // first cycles; detection waits until that transient has passed.
    assign w_edge_hit = (arm_q == 2'd3) ? ((w_rise & w_rise_en) | (w_fall & w_fall_en))
                                        : '0;

    assign irq = |(status_q & mask_q);
`else
    gpio_sync_edge #(.WIDTH(WIDTH)) u_sync (
        .clk    (clk),
        .reset  (reset),
        .pin_in (gpio_in),
        .sync   (w_sync)
    );

    assign irq = 1'b0;
`endif

    // Read mux; SET, CLR and unimplemented registers return 0.
    always_comb begin
        w_rdata = '0;
        case (w_reg_sel)
            GPIO_OUT:    w_rdata[WIDTH-1:0] = out_q;
            GPIO_DIR:    w_rdata[WIDTH-1:0] = dir_q;
            GPIO_IN:     w_rdata[WIDTH-1:0] = w_sync;
`ifdef GPIO_IRQ_EN
            GPIO_MASK:   w_rdata[WIDTH-1:0] = mask_q;
            GPIO_STATUS: w_rdata[WIDTH-1:0] = status_q;
            GPIO_EDGE:   w_rdata            = edge_q;
`endif
            default:     w_rdata = '0;
        endcase
    end

    // Bus FSM and register next-state.
    always_comb begin
        state_d    = state_q;
        out_d      = out_q;
        dir_d      = dir_q;
        data_out_d = '0;
        ready      = 1'b0;
`ifdef GPIO_IRQ_EN
        mask_d     = mask_q;
        edge_d     = edge_q;
        status_d   = status_q;
        arm_d      = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
`endif

        case (state_q)
            IDLE: begin
                if (wen || ren) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // wen+ren together is a write; data_out stays 0 in that case.
        if (state_q == IDLE && wen) begin
            case (w_reg_sel)
                GPIO_OUT:    out_d    = w_wdata;
                GPIO_DIR:    dir_d    = w_wdata;
                GPIO_SET:    out_d    = out_q | w_wdata;
                GPIO_CLR:    out_d    = out_q & ~w_wdata;
`ifdef GPIO_IRQ_EN
                GPIO_MASK:   mask_d   = w_wdata;
                GPIO_STATUS: status_d = status_q & ~w_wdata;
                GPIO_EDGE:   edge_d   = data_in & C_EDGE_WMASK;
`endif
                default: ;
            endcase
        end else if (state_q == IDLE && ren) begin
            data_out_d = w_rdata;
        end

`ifdef GPIO_IRQ_EN
        // Applied after the W1C so a same-cycle edge keeps the bit set.
        status_d = status_d | w_edge_hit;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            out_q      <= '0;
            dir_q      <= '0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            dir_q      <= dir_d;
            data_out_q <= data_out_d;
        end
    end

`ifdef GPIO_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q   <= '0;
            status_q <= '0;
            edge_q   <= '0;
            arm_q    <= '0;
        end else begin
            mask_q   <= mask_d;
            status_q <= status_d;
            edge_q   <= edge_d;
            arm_q    <= arm_d;
        end
    end
`endif

    assign data_out = data_out_q;
    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_port
// Description : Self-checking bench for gpio_port (WIDTH=16 main instance,
//               WIDTH=4 side instance). A cycle-level reference model built
//               from the register-map rules predicts every output.
//               Honours GPIO_IRQ_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_port;

`ifdef GPIO_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] address;
    logic [31:0] data_in;
    logic        wen, ren;
    logic [31:0] data_out, data_out4;
    logic        ready, ready4;
    logic [15:0] gpio_in, gpio_out, gpio_oe;
    logic [3:0]  gpio_in4, gpio_out4, gpio_oe4;
    logic        irq, irq4;

    assign gpio_in4 = gpio_in[3:0];

    always #5 clk = ~clk;

    gpio_port #(.WIDTH(16), .ADDR_W(16)) dut (
        .clk(clk), .reset(reset), .address(address), .data_in(data_in),
        .wen(wen), .ren(ren), .data_out(data_out), .ready(ready),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    gpio_port #(.WIDTH(4), .ADDR_W(16)) dut4 (
        .clk(clk), .reset(reset), .address(address), .data_in(data_in),
        .wen(wen), .ren(ren), .data_out(data_out4), .ready(ready4),
        .gpio_in(gpio_in4), .gpio_out(gpio_out4), .gpio_oe(gpio_oe4), .irq(irq4)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [15:0] m_out, m_dir, m_mask, m_status;
    logic [31:0] m_edge, m_rdata;
    bit          m_ack;
    logic [15:0] hist[$];   // pin value sampled at each rising edge since reset release

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pin_at(input int j);
        if (j >= 1 && j <= hist.size()) return hist[j-1];
        return 16'h0;
    endfunction

    task automatic model_reset();
        m_out = '0; m_dir = '0; m_mask = '0; m_status = '0;
        m_edge = '0; m_rdata = '0; m_ack = 1'b0;
        hist.delete();
    endtask

    // One clock: apply the spec rules at the rising edge, check at the falling edge.
    task automatic tick();
        int          k;
        logic [2:0]  sel;
        logic [15:0] in_now, in_prev, hit;
        logic [31:0] old_edge;
        @(posedge clk);
        hist.push_back(gpio_in);
        k        = hist.size();
        in_now   = pin_at(k - 2);   // IN lags the pins by two cycles
        in_prev  = pin_at(k - 3);
        old_edge = m_edge;
        sel      = address[4:2];
        if (m_ack) begin
            m_ack = 1'b0;
        end else if (wen || ren) begin
            m_ack   = 1'b1;
            m_rdata = 32'h0;
            if (wen) begin
                case (sel)
                    3'd0: m_out = data_in[15:0];
                    3'd1: m_dir = data_in[15:0];
                    3'd3: m_out = m_out | data_in[15:0];
                    3'd4: m_out = m_out & ~data_in[15:0];
                    3'd5: if (IRQ_ON) m_mask = data_in[15:0];
                    3'd6: if (IRQ_ON) m_status = m_status & ~data_in[15:0];
                    3'd7: if (IRQ_ON) m_edge = data_in;
                    default: ;
                endcase
            end else begin
                case (sel)
                    3'd0: m_rdata = {16'h0, m_out};
                    3'd1: m_rdata = {16'h0, m_dir};
                    3'd2: m_rdata = {16'h0, in_now};
                    3'd5: m_rdata = IRQ_ON ? {16'h0, m_mask} : 32'h0;
                    3'd6: m_rdata = IRQ_ON ? {16'h0, m_status} : 32'h0;
                    3'd7: m_rdata = IRQ_ON ? m_edge : 32'h0;
                    default: m_rdata = 32'h0;
                endcase
            end
        end
        // Edges count only once three cycles have elapsed since reset release.
        hit = (k >= 4) ? ((in_now & ~in_prev & old_edge[15:0]) |
                          (~in_now & in_prev & old_edge[31:16])) : 16'h0;
        if (IRQ_ON) m_status = m_status | hit;
        @(negedge clk);
        chk("ready", 32'(ready), 32'(m_ack));
        if (m_ack) chk("rdata", data_out, m_rdata);
        chk("gpio_out", 32'(gpio_out), 32'(m_out));
        chk("gpio_oe", 32'(gpio_oe), 32'(m_dir));
        chk("irq", 32'(irq), 32'(|(m_status & m_mask)));
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        address = a; data_in = d; wen = 1'b1; ren = 1'b0;
        tick();
        wen = 1'b0;
        tick();
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [31:0] v);
        address = a; ren = 1'b1; wen = 1'b0;
        tick();
        v   = data_out;
        ren = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [1:0]  r;
        reset = 1'b1; wen = 1'b0; ren = 1'b0; address = '0; data_in = '0;
        gpio_in = 16'hAA55;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Make outputs non-zero, then reset in the middle of an access.
        bus_write(16'h0000, 32'h0000_1234);
        bus_write(16'h0004, 32'h0000_00FF);
        address = 16'h0000; data_in = 32'h0000_BEEF; wen = 1'b1;
        tick();
        #2 reset = 1'b1;
        #1;
        chk("rst_gpio_out", 32'(gpio_out), 32'h0);
        chk("rst_gpio_oe", 32'(gpio_oe), 32'h0);
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        wen = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Enable every detector right away: pins high at reset must not fire.
        bus_write(16'h001C, 32'hFFFF_FFFF);
        bus_write(16'h0014, 32'h0000_FFFF);
        bus_read(16'h0018, v);
        chk("post_rst_status", v, 32'h0);
        bus_read(16'h0008, v);
        chk("post_rst_in", v, 32'h0000_AA55);

        // Set / clear
        bus_write(16'h0000, 32'h0000_00F0);
        bus_write(16'h000C, 32'h0000_0003);
        bus_write(16'h0010, 32'h0000_0010);
        chk("setclr_out", 32'(gpio_out), 32'h0000_00E3);
        bus_read(16'h000C, v);
        chk("set_reads0", v, 32'h0);

        // Direction and read-only IN
        bus_write(16'h0004, 32'h0000_FF00);
        chk("dir_oe", 32'(gpio_oe), 32'h0000_FF00);
        bus_read(16'h0004, v);
        chk("dir_rd", v, 32'h0000_FF00);
        bus_write(16'h0008, 32'h0000_1234);
        bus_read(16'h0008, v);
        chk("in_ro", v, 32'h0000_AA55);

`ifdef GPIO_IRQ_EN
        // Edge interrupt on pin 0
        bus_write(16'h001C, 32'h0001_0001);
        bus_write(16'h0014, 32'h0000_0001);
        gpio_in = 16'h0000;
        repeat (4) tick();
        bus_write(16'h0018, 32'h0000_FFFF);
        chk("irq_cleared", 32'(irq), 32'h0);
        gpio_in[0] = 1'b1;
        tick();
        chk("irq_lat1", 32'(irq), 32'h0);
        tick();
        chk("irq_lat2", 32'(irq), 32'h0);
        tick();
        chk("irq_lat3", 32'(irq), 32'h1);
        bus_read(16'h0018, v);
        chk("status_rise", v, 32'h0000_0001);
        bus_write(16'h0018, 32'h0000_0001);
        chk("irq_w1c", 32'(irq), 32'h0);
        gpio_in[0] = 1'b0;
        repeat (3) tick();
        chk("irq_fall", 32'(irq), 32'h1);

        // W1C landing on the same edge as a new detection
        bus_write(16'h0018, 32'h0000_0001);
        gpio_in[0] = 1'b1;
        tick();
        tick();
        address = 16'h0018; data_in = 32'h0000_0001; wen = 1'b1;
        tick();
        wen = 1'b0;
        tick();
        bus_read(16'h0018, v);
        chk("set_beats_clr", v, 32'h0000_0001);
`else
        bus_write(16'h0014, 32'hFFFF_FFFF);
        bus_write(16'h0018, 32'hFFFF_FFFF);
        bus_write(16'h001C, 32'hFFFF_FFFF);
        gpio_in = 16'h0F0F;
        repeat (4) tick();
        bus_read(16'h0014, v);
        chk("noirq_mask", v, 32'h0);
        bus_read(16'h0018, v);
        chk("noirq_status", v, 32'h0);
        bus_read(16'h001C, v);
        chk("noirq_edge", v, 32'h0);
        chk("noirq_irq", 32'(irq), 32'h0);
        chk("noirq_irq4", 32'(irq4), 32'h0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) gpio_in = gpio_in ^ 16'($urandom & $urandom);
            if (!m_ack && $urandom_range(0, 1) == 1) begin
                address = 16'($urandom);
                data_in = $urandom;
                r       = 2'($urandom_range(1, 3));
                wen     = r[0];
                ren     = r[1];
            end else begin
                wen = 1'b0;
                ren = 1'b0;
            end
            tick();
        end
        wen = 1'b0; ren = 1'b0;
        tick();

        // Narrow instance: bits above WIDTH are not stored
        bus_write(16'h0000, 32'hFFFF_FFFF);
        chk("w4_gpio_out", 32'(gpio_out4), 32'h0000_000F);
        address = 16'h0000; ren = 1'b1;
        tick();
        chk("w4_out_rd", data_out4, 32'h0000_000F);
        chk("w4_ready", 32'(ready4), 32'h1);
        ren = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
